// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths and the writeback queue entry type
package mips_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-match select of a pending write over an age-ordered ring
module wb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     rd_ptr,
  input  logic [ADDR_W-1:0] lookup,
  output logic              hit,
  output logic [DATA_W-1:0] data
);
  logic [PW-1:0] idx;
  // Walk oldest to youngest so the last match seen is the youngest one
  always_comb begin
    hit = 1'b0;
    data = '0;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && entries[idx].rd == lookup && lookup != REG_ZERO) begin
        hit = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of pending register writes with read-port forwarding
module regfile_write_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_enable,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] lookup_reg1,
  input  logic [ADDR_W-1:0] lookup_reg2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] off;
  logic push, pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign in_ready = !full;
  // $0 writes complete the handshake but are never stored
  assign push = in_valid && in_ready && in_reg != REG_ZERO;
  assign pop = reg_write;
  assign reg_write = !empty && wb_enable;
  assign write_reg = empty ? '0 : mem[rd_ptr].rd;
  assign write_data = empty ? '0 : mem[rd_ptr].data;
  always_comb begin
    valid = '0;
    off = '0;
    for (int k = 0; k < DEPTH; k++) begin
      off = PW'(k) - rd_ptr;
      valid[k] = CW'(off) < count;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{rd: in_reg, data: in_data};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
    end
  end
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries(mem), .valid(valid), .rd_ptr(rd_ptr), .lookup(lookup_reg1),
    .hit(fwd_hit1), .data(fwd_data1)
  );
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries(mem), .valid(valid), .rd_ptr(rd_ptr), .lookup(lookup_reg2),
    .hit(fwd_hit2), .data(fwd_data2)
  );
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed checks of queueing, draining, forwarding and reset
module tb_regfile_write_queue;
  logic clk = 0;
  logic reset, in_valid, in_ready, wb_enable, reg_write;
  logic fwd_hit1, fwd_hit2, empty, full;
  logic [4:0] in_reg, write_reg, lookup_reg1, lookup_reg2;
  logic [31:0] in_data, write_data, fwd_data1, fwd_data2;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_write_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .wb_enable(wb_enable),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .empty(empty), .full(full)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1; in_reg = r; in_data = d;
    tick();
    in_valid = 0;
  endtask
  initial begin
    reset = 1; in_valid = 0; in_reg = 0; in_data = 0; wb_enable = 1;
    lookup_reg1 = 5; lookup_reg2 = 0;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_fwd_hit1", 32'(fwd_hit1), 0);
    chk("rst_fwd_data1", fwd_data1, 0);
    // single write, latency of one cycle to the write port
    push(5, 32'hDEADBEEF);
    #1;
    chk("t1_reg_write", 32'(reg_write), 1);
    chk("t1_write_reg", 32'(write_reg), 5);
    chk("t1_write_data", write_data, 32'hDEADBEEF);
    chk("t1_fwd_head_hit", 32'(fwd_hit1), 1);
    chk("t1_fwd_head_data", fwd_data1, 32'hDEADBEEF);
    tick();
    chk("t1_empty", 32'(empty), 1);
    chk("t1_reg_write_off", 32'(reg_write), 0);
    // fill with drain stalled, then drain in order
    wb_enable = 0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
    chk("t2_full", 32'(full), 1);
    chk("t2_in_ready", 32'(in_ready), 0);
    chk("t2_count4", 32'(count), 4);
    chk("t2_stall_reg_write", 32'(reg_write), 0);
    push(9, 32'h999);
    chk("t2_fifth_rejected", 32'(count), 4);
    wb_enable = 1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_we", 32'(reg_write), 1);
      chk("t2_drain_reg", 32'(write_reg), 32'(i));
      chk("t2_drain_data", write_data, 32'h100 + 32'(i));
      tick();
    end
    chk("t2_drained_empty", 32'(empty), 1);
    // youngest-match forwarding
    wb_enable = 0;
    push(7, 32'h1);
    push(7, 32'h2);
    lookup_reg1 = 7; lookup_reg2 = 8;
    #1;
    chk("t3_count", 32'(count), 2);
    chk("t3_hit1", 32'(fwd_hit1), 1);
    chk("t3_data1", fwd_data1, 32'h2);
    chk("t3_hit2", 32'(fwd_hit2), 0);
    chk("t3_data2", fwd_data2, 0);
    wb_enable = 1;
    #1;
    chk("t3_first_reg", 32'(write_reg), 7);
    chk("t3_first_data", write_data, 32'h1);
    chk("t3_fwd_while_draining", fwd_data1, 32'h2);
    tick();
    chk("t3_second_data", write_data, 32'h2);
    chk("t3_fwd_last", fwd_data1, 32'h2);
    tick();
    chk("t3_hit1_gone", 32'(fwd_hit1), 0);
    chk("t3_empty", 32'(empty), 1);
    // writes to $0 are accepted and dropped
    in_valid = 1; in_reg = 0; in_data = 32'hFFFFFFFF; lookup_reg1 = 0;
    #1;
    chk("t4_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    chk("t4_count", 32'(count), 0);
    chk("t4_reg_write", 32'(reg_write), 0);
    chk("t4_hit1", 32'(fwd_hit1), 0);
    chk("t4_data1", fwd_data1, 0);
    tick();
    chk("t4_reg_write_later", 32'(reg_write), 0);
    // reset discards a full queue
    wb_enable = 0;
    for (int i = 10; i <= 13; i++) push(5'(i), 32'(i));
    chk("t5_full", 32'(full), 1);
    reset = 1;
    tick();
    reset = 0; wb_enable = 1; lookup_reg1 = 10;
    #1;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_full_clear", 32'(full), 0);
    chk("t5_fwd_hit1", 32'(fwd_hit1), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_write", 32'(reg_write), 0);
      tick();
    end
    // steady push+pop stream at count 2, wrapping the pointers twice
    wb_enable = 0;
    push(20, 32'h1020);
    push(21, 32'h1021);
    wb_enable = 1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_reg = 5'(22 + k); in_data = 32'h1022 + 32'(k);
      #1;
      chk("t6_count", 32'(count), 2);
      chk("t6_we", 32'(reg_write), 1);
      chk("t6_reg", 32'(write_reg), 32'(20 + k));
      chk("t6_data", write_data, 32'h1020 + 32'(k));
      tick();
    end
    in_valid = 0;
    #1;
    chk("t6_count_end", 32'(count), 2);
    chk("t6_tail_reg", 32'(write_reg), 28);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
